// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction-fetch stage:
//   FETCH_BITS    default PC / address width
//   FETCH_INST_W  default instruction width
//   INST_BYTES    bytes per instruction, used as the sequential PC increment
//   fetch_state_t fetch controller states (IDLE / RUN / DROP)
//   fetch_entry_t one buffered fetch result {inst, pc}
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int FETCH_BITS   = 64;
    localparam int FETCH_INST_W = 32;
    localparam int INST_BYTES   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // reset state, no fetching
        RUN  = 2'd1,  // normal sequential fetching
        DROP = 2'd2   // one cycle after a redirect that caught a read in flight
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_INST_W-1:0] inst;
        logic [FETCH_BITS-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// riscv_fetch_queue_if
// Bundles the fetch stage's three channels:
//   imem_*      synchronous instruction-memory read (data one cycle after req)
//   dec_*       valid/ready handshake towards decode
//   redirect_*  one-cycle branch/jump redirect from execute
//   fetch_fault misaligned-redirect flag
// Modports:
//   master : the fetch stage (drives imem_req/addr, dec_valid/inst/pc, fetch_fault)
//   slave  : the environment (memory, decode, execute)
// -----------------------------------------------------------------------------
interface riscv_fetch_queue_if
    import riscv_pkg::*;
#(
    parameter int Bits = FETCH_BITS,
    parameter int N    = FETCH_INST_W
);

    logic            imem_req;
    logic [Bits-1:0] imem_addr;
    logic [N-1:0]    imem_rdata;
    logic            dec_valid;
    logic [N-1:0]    dec_inst;
    logic [Bits-1:0] dec_pc;
    logic            dec_ready;
    logic            redirect_valid;
    logic [Bits-1:0] redirect_pc;
    logic            fetch_fault;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_inst, dec_pc, fetch_fault,
        input  imem_rdata, dec_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_inst, dec_pc, fetch_fault,
        output imem_rdata, dec_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Circular queue of fetch entries with a single-cycle flush.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   flush_i      empties the queue (head = tail = 0, count = 0); beats push/pop
//   push_i       write push_data_i at tail (ignored when full)
//   push_data_i  entry to write
//   pop_i        advance head (ignored when empty)
//   head_o       entry at head (meaningless when empty_o)
//   count_o      number of valid entries, $clog2(Depth)+1 bits
//   full_o       count == Depth
//   empty_o      count == 0
// Depth must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int  Depth   = 4,
    parameter type entry_t = riscv_pkg::fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PtrW   = $clog2(Depth);
    localparam int CountW = $clog2(Depth) + 1;

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CountW-1:0] count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CountW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + 1'b1;
            if (pop_ok)  head_d = head_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read once
    // count_q says it was written, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch_queue.sv
// -----------------------------------------------------------------------------
// riscv_fetch_queue
// Instruction-fetch stage: generates the PC, issues synchronous reads to the
// instruction memory, buffers returned instructions with their PCs in a
// fetch_fifo and hands them to decode over valid/ready. A one-cycle redirect
// from execute flushes the queue and discards any read in flight.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   bus        riscv_fetch_queue_if.master (imem_*, dec_*, redirect_*, fetch_fault)
// Parameters:
//   Bits, N    address / instruction width; must match the widths of
//              riscv_pkg::fetch_entry_t, which is the buffered entry type
//   Depth      queue entries (power of two, >= 2)
//   ResetPC    first fetch address after reset
// Build option:
//   FETCH_MISALIGN_TRAP_EN  defined: a redirect to a non-word-aligned PC sets
//                           a sticky fetch_fault and stops fetching.
//                           undefined: fetch_fault is 0 and the redirect PC is
//                           word-aligned by clearing its two low bits.
// -----------------------------------------------------------------------------
module riscv_fetch_queue
    import riscv_pkg::*;
#(
    parameter int              Bits    = FETCH_BITS,
    parameter int              N       = FETCH_INST_W,
    parameter int              Depth   = 4,
    parameter logic [Bits-1:0] ResetPC = '0
) (
    input logic                 clk,
    input logic                 rst,
    riscv_fetch_queue_if.master bus
);

    localparam int CountW = $clog2(Depth) + 1;
    localparam int OccW   = CountW + 1;

    fetch_state_t      state_q, state_d;
    logic [Bits-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [Bits-1:0]   inflight_pc_q, inflight_pc_d;
    logic [Bits-1:0]   redirect_target;
    logic [N-1:0]      rdata;
    logic              fetch_stop;
    logic              fetching, req, push, pop, dec_valid;
    logic              fifo_full, fifo_empty;
    logic [CountW-1:0] count;
    logic [OccW-1:0]   occupancy;
    fetch_entry_t      push_entry, head_entry;

    // Redirect takes priority: it suppresses the pop, the push of a returning
    // read, and any new request in the same cycle.
    assign dec_valid = ~fifo_empty;
    assign pop       = dec_valid & bus.dec_ready & ~bus.redirect_valid;
    assign push      = inflight_q & (state_q != DROP) & ~bus.redirect_valid;

    // Slots already promised: buffered entries plus the read still returning,
    // less the one leaving this cycle. Requesting only below Depth guarantees
    // every response finds a free slot.
    assign occupancy = OccW'(count) + OccW'(inflight_q) - OccW'(pop);
    assign fetching  = (state_q == RUN) || (state_q == DROP);
    assign req       = fetching & ~bus.redirect_valid & ~fetch_stop
                     & ~(fifo_full & ~pop) & (occupancy < OccW'(Depth));

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    assign redirect_target = bus.redirect_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end

    assign fetch_stop      = fault_q;
    assign bus.fetch_fault = fault_q;
`else
    assign redirect_target = bus.redirect_pc & ~Bits'(3);
    assign fetch_stop      = 1'b0;
    assign bus.fetch_fault = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = req;
        inflight_pc_d = inflight_pc_q;

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = RUN;
            DROP:    state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (req) begin
            pc_d          = pc_q + Bits'(INST_BYTES);
            inflight_pc_d = pc_q;
        end

        if (bus.redirect_valid) begin
            pc_d    = redirect_target;
            state_d = inflight_q ? DROP : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= ResetPC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign rdata           = bus.imem_rdata;
    assign push_entry.inst = rdata;
    assign push_entry.pc   = inflight_pc_q;

    fetch_fifo #(
        .Depth   (Depth),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.dec_valid = dec_valid;
    // Masked so an empty queue presents zeros rather than stale storage.
    assign bus.dec_inst  = dec_valid ? head_entry.inst : '0;
    assign bus.dec_pc    = dec_valid ? head_entry.pc : '0;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch_queue
// Self-checking bench for riscv_fetch_queue. A memory model answers every
// request one cycle later with an address-tagged NOP (opcode 0x13, address
// bits in the upper field). The expected decode stream (PCs) is queued when
// stimulus is issued; a monitor pops and compares on every accepted
// handshake. Directed cycle-exact checks cover reset, start-up latency,
// back-pressure, redirect, misaligned redirect (FETCH_MISALIGN_TRAP_EN) and
// mid-stream reset.
// -----------------------------------------------------------------------------
module tb_riscv_fetch_queue;
    import riscv_pkg::*;

    localparam int Bits  = 64;
    localparam int N     = 32;
    localparam int Depth = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    riscv_fetch_queue_if #(.Bits(Bits), .N(N)) bus ();

    riscv_fetch_queue #(
        .Bits    (Bits),
        .N       (N),
        .Depth   (Depth),
        .ResetPC (64'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] inst_of(logic [63:0] a);
        return {a[26:2], 7'h13};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_stream(logic [63:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 64'(4 * i));
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_req"},   64'(bus.imem_req),    64'h0);
        check({tag, "_addr"},  bus.imem_addr,        64'h0);
        check({tag, "_valid"}, 64'(bus.dec_valid),   64'h0);
        check({tag, "_inst"},  64'(bus.dec_inst),    64'h0);
        check({tag, "_pc"},    bus.dec_pc,           64'h0);
        check({tag, "_fault"}, 64'(bus.fetch_fault), 64'h0);
    endtask

    // Cycle-exact start-up after reset release: E0 is the first edge of c=0.
    task automatic check_boot(string tag);
        @(negedge clk);
        check({tag, "_idle_req"}, 64'(bus.imem_req), 64'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check({tag, "_req"},   64'(bus.imem_req),  64'h1);
            check({tag, "_addr"},  bus.imem_addr,      64'(4 * c));
            check({tag, "_valid"}, 64'(bus.dec_valid), 64'(c >= 2));
            if (c >= 2) check({tag, "_pc"}, bus.dec_pc, 64'(4 * (c - 2)));
        end
    endtask

    // Memory model: a request seen in one cycle is answered in the next.
    initial begin
        logic        r;
        logic [63:0] a;
        bus.imem_rdata = 32'hdeadbeef;
        forever begin
            @(negedge clk);
            r = bus.imem_req;
            a = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rdata = r ? inst_of(a) : 32'hdeadbeef;
        end
    end

    // Scoreboard monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1
            && bus.redirect_valid === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_unexpected: got pc 0x%0h with no entry expected", bus.dec_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("mon_pc",   bus.dec_pc,        e);
                check("mon_inst", 64'(bus.dec_inst), 64'(inst_of(e)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst                = 1'b0;
        bus.dec_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        exp_q.delete();

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");

        // Release reset with decode always ready
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.dec_ready = 1'b1;
        expect_stream(64'h0);
        check_boot("boot");

        // Back-pressure: 0x10..0x1C buffered, 0x20 next to fetch, no request
        @(posedge clk); #1;
        bus.dec_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_req",   64'(bus.imem_req),  64'h0);
        check("stall_addr",  bus.imem_addr,      64'h20);
        check("stall_valid", 64'(bus.dec_valid), 64'h1);
        check("stall_pc",    bus.dec_pc,         64'h10);

        // Drain with no gap; fetching resumes in the first drain cycle
        @(posedge clk); #1;
        bus.dec_ready = 1'b1;
        @(negedge clk);
        check("drain_req",  64'(bus.imem_req), 64'h1);
        check("drain_addr", bus.imem_addr,     64'h20);
        check("drain_pc0",  bus.dec_pc,        64'h10);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            check("drain_valid", 64'(bus.dec_valid), 64'h1);
            check("drain_pc",    bus.dec_pc,         64'(32'h10 + 4 * i));
        end

        // Redirect to 0x40 with a read in flight, queue non-empty, pop requested
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h40;
        expect_stream(64'h40);
        @(negedge clk);
        check("redir_no_req",   64'(bus.imem_req),  64'h0);
        check("redir_nonempty", 64'(bus.dec_valid), 64'h1);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_t1_valid", 64'(bus.dec_valid), 64'h0);
        check("redir_t1_req",   64'(bus.imem_req),  64'h1);
        check("redir_t1_addr",  bus.imem_addr,      64'h40);
        @(negedge clk);
        check("redir_t2_valid", 64'(bus.dec_valid), 64'h0);
        check("redir_t2_addr",  bus.imem_addr,      64'h44);
        @(negedge clk);
        check("redir_t3_valid", 64'(bus.dec_valid), 64'h1);
        check("redir_t3_pc",    bus.dec_pc,         64'h40);
        repeat (3) @(negedge clk);

        // Misaligned redirect to 0x42
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h42;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_q.delete();
`else
        expect_stream(64'h40);
`endif
        @(negedge clk);
        check("mis_t0_req", 64'(bus.imem_req), 64'h0);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check("mis_fault", 64'(bus.fetch_fault), 64'h1);
            check("mis_req",   64'(bus.imem_req),    64'h0);
            check("mis_valid", 64'(bus.dec_valid),   64'h0);
        end
`else
        @(negedge clk);
        check("mis_t1_fault", 64'(bus.fetch_fault), 64'h0);
        check("mis_t1_req",   64'(bus.imem_req),    64'h1);
        check("mis_t1_addr",  bus.imem_addr,        64'h40);
        repeat (2) @(negedge clk);
        check("mis_t3_valid", 64'(bus.dec_valid), 64'h1);
        check("mis_t3_pc",    bus.dec_pc,         64'h40);
        repeat (2) @(negedge clk);
`endif

        // Reset mid-stream for one cycle: outputs clear at once, restart at 0
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b1;
        expect_stream(64'h0);
        check_boot("reboot");
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_queue.md
# riscv_fetch_queue

Instruction-fetch stage of the RISC-V core. Generates the program counter, issues synchronous reads to the instruction memory, and buffers returned instructions in a small queue. Presents them with their PCs to the decode stage over a valid/ready handshake. Accepts a one-cycle redirect from execute (branch/jump) that flushes all buffered and in-flight instructions.

## Interface
- Bits, 64, PC/address width
- N, 32, instruction width
- Depth, 4, queue entries (power of two, ≥2)
- ResetPC, 0, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  Bits  byte address of request
- imem_rdata  in  N  read data, valid exactly one cycle after the cycle imem_req was high
- dec_valid  out  1  head entry valid
- dec_inst  out  N  head instruction
- dec_pc  out  Bits  PC of head instruction
- dec_ready  in  1  decode consumes head when dec_valid & dec_ready
- redirect_valid  in  1  one-cycle redirect pulse from execute
- redirect_pc  in  Bits  new fetch address
- fetch_fault  out  1  misaligned redirect flag (see Configuration)

## Operation
- FSM states:
  - IDLE: reset state. Leaves for RUN on the first clock edge with rst high.
  - RUN: normal fetching.
  - DROP: one cycle, entered on redirect while a read is in flight. Discards imem_rdata, then returns to RUN.
- Registers:
  - pc_q: next fetch address.
  - inflight_q: read outstanding; its PC is kept alongside.
  - Circular queue of {inst, pc} with head/tail pointers and a count (width clog2(Depth)+1).
- Request rule, in RUN (or DROP):
  - Condition: imem_req = 1 iff count + inflight_q − pop < Depth and redirect_valid = 0.
  - imem_addr = pc_q.
  - On request, pc_q ← pc_q + 4 (modulo 2^Bits, wraps silently).
- Response: the cycle after a request, imem_rdata with its PC is written at tail. In DROP it is discarded.
- Pop: dec_valid & dec_ready advances head. Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid = 1):
  - Takes priority over push, pop and request.
  - Queue is emptied (count ← 0, head = tail) and pc_q ← redirect_pc.
  - Enters DROP if inflight_q = 1, otherwise stays in RUN.
  - No request is issued in the redirect cycle.
- Full: no request is issued, so no response is ever lost. Empty: dec_valid = 0. dec_inst and dec_pc are don't-care.

## Timing
- Reset values: imem_req = 0, imem_addr = ResetPC, dec_valid = 0, dec_inst = 0, dec_pc = 0, fetch_fault = 0, pc_q = ResetPC, count = 0, FSM in IDLE.
- Edge E0 is the first rising edge with rst high:
  - FSM enters RUN after E0, so imem_req = 1 with ResetPC in the cycle after E0.
  - The response is written at E2.
  - dec_valid is first high after E2.
- Fetch-to-decode latency is 2 cycles. Steady state gives 1 instruction per cycle when dec_ready = 1.
- Redirect in cycle t:
  - dec_valid = 0 in cycle t+1.
  - Request to redirect_pc in cycle t+1.
  - First new instruction is valid in cycle t+3 (2-cycle bubble).
- rst low mid-operation: all state clears immediately (asynchronous). In-flight data is ignored, and fetch restarts at ResetPC.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0] ≠ 0 sets fetch_fault = 1 (sticky until reset) and issues no further requests.
  - The queue is flushed as usual.
- FETCH_MISALIGN_TRAP_EN undefined:
  - fetch_fault is tied 0.
  - redirect_pc[1:0] is forced to 0 before loading pc_q.

## Structure
- Shared package riscv_pkg holds:
  - Typedef fetch_state_t (IDLE/RUN/DROP).
  - Typedef fetch_entry_t {inst, pc}.
  - Constant INST_BYTES = 4.
- One sub-module: fetch_fifo, the circular queue with flush, count and full/empty, parameterised by Depth and the entry type. The PC/FSM logic stays in riscv_fetch_queue.

## Test plan
- Reset release with the memory model returning 0x00000013 (NOP) at every address and dec_ready = 1 → imem_addr 0, 4, 8…; dec_pc 0, 4, 8… one per cycle, first dec_valid 2 cycles after E0.
- dec_ready = 0 for 10 cycles → exactly Depth = 4 entries buffered (PCs 0…0xC), imem_req low. Raising dec_ready then drains 0, 4, 8, 0xC in order with no gap, loss or duplicate.
- redirect_valid with redirect_pc = 0x40 while a read is in flight and the queue is non-empty → in-flight data dropped, next request to 0x40, next dec_pc = 0x40 three cycles later.
- redirect_valid and pop in the same cycle → redirect wins, dec_valid = 0 next cycle, count = 0.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc = 0x42 → fetch_fault = 1, no further imem_req. Without the macro, fetch resumes at 0x40.
- rst driven low mid-stream for 1 cycle → all outputs immediately at reset values, restart from PC 0.
